// File: rtl/stim_pkg.sv
// Shared types for the table-driven stimulus player: FSM states, table entry layout, idle key level.
package stim_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RST_PULSE,
      LOAD,
      HOLD,
      DONE
   } state_t;

   localparam int DEF_SW_W  = 10;
   localparam int DEF_KEY_W = 4;
   localparam int DEF_DUR_W = 24;

   // Field order matches the packed table word {dur, sw, key} held in the RAM.
   typedef struct packed {
      logic [DEF_DUR_W-1:0] dur;
      logic [DEF_SW_W-1:0]  sw;
      logic [DEF_KEY_W-1:0] key;
   } entry_t;

   localparam logic [DEF_KEY_W-1:0] KEY_IDLE = '1;

endpackage

// File: rtl/stim_table_ram.sv
// Stimulus table storage: simple dual-port RAM, one write port, registered read (1-cycle latency).
// No reset on contents; the read port samples every cycle and never stalls.
module stim_table_ram
   import stim_pkg::*;
#(
   parameter int AW = 4,
   parameter int W  = 38
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data
);

   logic [W-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/stim_sequencer.sv
// Table-driven SW/KEY stimulus player: reset pulse, then back-to-back entries; read path is 1 cycle, prefetched.
// No backpressure: stop aborts at once; writes are dropped while busy. Key bounce model under STIM_KEY_BOUNCE_EN.
module stim_sequencer
   import stim_pkg::*;
#(
   parameter int SW_W       = DEF_SW_W,
   parameter int KEY_W      = DEF_KEY_W,
   parameter int DEPTH      = 16,
   parameter int DUR_W      = DEF_DUR_W,
   parameter int RST_CYCLES = 4
`ifdef STIM_KEY_BOUNCE_EN
   ,
   parameter int BOUNCE_CYC = 8
`endif
) (
   input  logic                     CLOCK_50,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     loop_en,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [DUR_W-1:0]         wr_dur,
   input  logic [SW_W-1:0]          wr_sw,
   input  logic [KEY_W-1:0]         wr_key,
   output logic [SW_W-1:0]          SW_out,
   output logic [KEY_W-1:0]         KEY_out,
   output logic                     dut_reset_n,
   output logic [$clog2(DEPTH)-1:0] step_idx,
   output logic                     busy,
   output logic                     done,
   output logic [7:0]               pass_cnt
);

   localparam int AW  = $clog2(DEPTH);
   localparam int RCW = $clog2(RST_CYCLES + 1);
   localparam int EW  = DUR_W + SW_W + KEY_W;

   typedef struct packed {
      logic [DUR_W-1:0] dur;
      logic [SW_W-1:0]  sw;
      logic [KEY_W-1:0] key;
   } ent_t;

   state_t           state, state_next;
   logic [AW-1:0]    step_next, rd_addr;
   logic [RCW-1:0]   rst_cnt;
   logic [DUR_W-1:0] hold_cnt;
   ent_t             rd_ent, ent0, ld_ent;
   logic             accept, ld_en, pass_inc, last_entry;

   assign busy = (state == RST_PULSE) || (state == LOAD) || (state == HOLD);
   assign done = (state == DONE);

   stim_table_ram #(
      .AW (AW),
      .W  (EW)
   ) u_ram (
      .clk     (CLOCK_50),
      .wr_en   (wr_en && !busy),
      .wr_addr (wr_addr),
      .wr_data ({wr_dur, wr_sw, wr_key}),
      .rd_addr (rd_addr),
      .rd_data (rd_ent)
   );

   // While holding entry k the RAM output must already carry entry k+1, so the
   // address tracks the index that will be current next cycle, plus one.
   assign last_entry = (rd_ent.dur == '0) || (step_idx == AW'(DEPTH - 1));
   assign rd_addr    = (state_next == HOLD) ? AW'(step_next + 1'b1) : '0;

   always_comb begin
      state_next = state;
      step_next  = step_idx;
      accept     = 1'b0;
      ld_en      = 1'b0;
      ld_ent     = rd_ent;
      pass_inc   = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start && !stop) begin
               state_next = RST_PULSE;
               step_next  = '0;
               accept     = 1'b1;
            end
         end
         RST_PULSE: begin
            if (stop)                                 state_next = IDLE;
            else if (rst_cnt == RCW'(RST_CYCLES - 1)) state_next = LOAD;
         end
         LOAD: begin
            if (stop) begin
               state_next = IDLE;
            end else if (rd_ent.dur == '0) begin
               state_next = DONE;
            end else begin
               state_next = HOLD;
               step_next  = '0;
               ld_en      = 1'b1;
            end
         end
         HOLD: begin
            if (stop) begin
               state_next = IDLE;
            end else if (hold_cnt == DUR_W'(1)) begin
               if (last_entry) begin
                  pass_inc = 1'b1;
                  if (loop_en) begin
                     step_next = '0;
                     ld_en     = 1'b1;
                     ld_ent    = ent0;
                  end else begin
                     state_next = DONE;
                  end
               end else begin
                  step_next = step_idx + 1'b1;
                  ld_en     = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state       <= IDLE;
         step_idx    <= '0;
         dut_reset_n <= 1'b1;
         SW_out      <= '0;
         rst_cnt     <= '0;
         hold_cnt    <= '0;
         pass_cnt    <= '0;
         ent0        <= '0;
      end else begin
         state       <= state_next;
         step_idx    <= step_next;
         dut_reset_n <= (state_next != RST_PULSE);
         if (accept) begin
            SW_out   <= '0;
            rst_cnt  <= '0;
            pass_cnt <= '0;
         end else if (state == RST_PULSE) begin
            rst_cnt <= rst_cnt + 1'b1;
         end
         // Entry 0 is kept aside so a loop can restart without a fetch bubble.
         if (state == LOAD) ent0 <= rd_ent;
         if (ld_en) begin
            SW_out   <= ld_ent.sw;
            hold_cnt <= ld_ent.dur;
         end else if (state == HOLD) begin
            hold_cnt <= hold_cnt - 1'b1;
         end
         if (pass_inc && (pass_cnt != 8'hFF)) pass_cnt <= pass_cnt + 1'b1;
      end
   end

`ifdef STIM_KEY_BOUNCE_EN
   logic [KEY_W-1:0] key_tgt, bnc_mask;
   logic [DUR_W-1:0] bnc_cnt;

   // Changed bits replay the old level first, then alternate until the window closes.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         KEY_out  <= '1;
         key_tgt  <= '1;
         bnc_mask <= '0;
         bnc_cnt  <= '0;
      end else if (accept) begin
         KEY_out  <= '1;
         key_tgt  <= '1;
         bnc_mask <= '0;
         bnc_cnt  <= '0;
      end else if (ld_en) begin
         KEY_out  <= key_tgt;
         key_tgt  <= ld_ent.key;
         bnc_mask <= ld_ent.key ^ key_tgt;
         bnc_cnt  <= (ld_ent.dur < DUR_W'(BOUNCE_CYC)) ? DUR_W'(ld_ent.dur - 1'b1)
                                                       : DUR_W'(BOUNCE_CYC - 1);
      end else if (state_next == HOLD) begin
         if (bnc_cnt != '0) begin
            KEY_out <= KEY_out ^ bnc_mask;
            bnc_cnt <= bnc_cnt - 1'b1;
         end else begin
            KEY_out <= key_tgt;
         end
      end
   end
`else
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         KEY_out <= '1;
      end else if (accept) begin
         KEY_out <= '1;
      end else if (ld_en) begin
         KEY_out <= ld_ent.key;
      end
   end
`endif

endmodule
